core_memory_stage: RTL and testbench

- Pipeline stage directly downstream of the execution stage.
- Takes ex_out (the ALU/shift/MDU result, or the effective address for loads and stores) and performs a data-memory access over a request/grant/response bus, or passes the result straight through.
- Presents a registered result to writeback through a valid/ready handshake.
- Handles byte-lane steering, load sign/zero extension and misalignment detection.

---
 rtl/lsu_control_pkg.sv | 22 ++
 rtl/core_load_align.sv | 18 +
 rtl/core_memory_stage.sv | 89 ++++++++
 tb/tb_core_memory_stage.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/lsu_control_pkg.sv
// lsu_control_pkg: load/store width codes and memory-stage FSM encoding.
package lsu_control_pkg;
  localparam int LSU_WIDTH_CODE = 3;
  typedef enum logic [LSU_WIDTH_CODE-1:0] {
    LSU_LB  = 3'd0,
    LSU_LH  = 3'd1,
    LSU_LW  = 3'd2,
    LSU_SB  = 3'd3,
    LSU_LBU = 3'd4,
    LSU_LHU = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SW  = 3'd7
  } lsu_op_e;
  typedef logic [1:0] mem_state_t;
  localparam mem_state_t ST_IDLE = 2'd0;
  localparam mem_state_t ST_REQ  = 2'd1;
  localparam mem_state_t ST_RESP = 2'd2;
  localparam mem_state_t ST_DONE = 2'd3;
  function automatic logic is_store(input logic [LSU_WIDTH_CODE-1:0] c);
    return c == LSU_SB || c == LSU_SH || c == LSU_SW;
  endfunction
endpackage

// File: rtl/core_load_align.sv
// core_load_align: picks the addressed byte/half-word lane of a load word and extends it.
module core_load_align
  import lsu_control_pkg::*;
(
  input  logic [31:0]               rdata,
  input  logic [1:0]                lane,
  input  logic [LSU_WIDTH_CODE-1:0] op,
  output logic [31:0]               data
);
  logic [31:0] sh;
  always_comb begin
    sh   = rdata >> {lane, 3'b000};
    data = op == LSU_LB  ? {{24{sh[7]}}, sh[7:0]} :
           op == LSU_LBU ? {24'd0, sh[7:0]} :
           op == LSU_LH  ? {{16{sh[15]}}, sh[15:0]} :
           op == LSU_LHU ? {16'd0, sh[15:0]} : rdata;
  end
endmodule

// File: rtl/core_memory_stage.sv
// core_memory_stage: data-memory access or pass-through, registered result to writeback.
module core_memory_stage
  import lsu_control_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [DATA_WIDTH-1:0]     ex_out,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  input  logic                      mem_op,
  input  logic [LSU_WIDTH_CODE-1:0] lsu_control,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_reg_write,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [DATA_WIDTH-1:0]     mem_addr,
  output logic [3:0]                mem_be,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_gnt,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic                      wb_reg_write,
  output logic                      wb_misalign
);
  mem_state_t                state;
  logic [LSU_WIDTH_CODE-1:0] op;
  logic [1:0]                lane;
  logic                      accept, store, misalign, go_bus;
  logic [3:0]                be_next;
  logic [DATA_WIDTH-1:0]     wdata_next, load_data;
  always_comb begin
    ex_ready   = state == ST_IDLE || (state == ST_DONE && wb_ready);
    wb_valid   = state == ST_DONE;
    accept     = ex_valid & ex_ready;
    store      = is_store(lsu_control);
    misalign   = ((lsu_control == LSU_LH || lsu_control == LSU_LHU || lsu_control == LSU_SH) && ex_out[0]) ||
                 ((lsu_control == LSU_LW || lsu_control == LSU_SW) && ex_out[1:0] != 2'b00);
    go_bus     = mem_op & ~misalign;
    be_next    = lsu_control == LSU_SB ? 4'b0001 << ex_out[1:0] :
                 lsu_control == LSU_SH ? 4'b0011 << ex_out[1:0] : 4'b1111;
    wdata_next = lsu_control == LSU_SB ? {4{ex_store_data[7:0]}} :
                 lsu_control == LSU_SH ? {2{ex_store_data[15:0]}} : ex_store_data;
  end
  core_load_align u_align (.rdata(mem_rdata), .lane(lane), .op(op), .data(load_data));
  // A grant with a same-cycle rvalid leaves REQ only; the response is taken in RESP.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= ST_IDLE;
      op           <= '0;
      lane         <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_misalign  <= 1'b0;
    end else if (accept) begin
      state        <= go_bus ? ST_REQ : ST_DONE;
      op           <= lsu_control;
      lane         <= ex_out[1:0];
      mem_req      <= go_bus;
      mem_we       <= go_bus & store;
      mem_addr     <= {ex_out[DATA_WIDTH-1:2], 2'b00};
      mem_be       <= be_next;
      mem_wdata    <= wdata_next;
      wb_data      <= ex_out;
      wb_rd        <= ex_rd;
      wb_reg_write <= ex_reg_write & ~(mem_op & (misalign | store));
      wb_misalign  <= mem_op & misalign;
    end else if (state == ST_REQ && mem_gnt) begin
      mem_req <= 1'b0;
      state   <= ST_RESP;
    end else if (state == ST_RESP && mem_rvalid) begin
      state <= ST_DONE;
      if (!is_store(op)) wb_data <= load_data;
    end else if (state == ST_DONE && wb_ready)
      state <= ST_IDLE;
endmodule

// File: tb/tb_core_memory_stage.sv
// tb_core_memory_stage: directed checks of the memory stage against hand-computed results.
module tb_core_memory_stage;
  import lsu_control_pkg::*;
  logic        clk, rst_n, ex_valid, ex_ready, mem_op, ex_reg_write;
  logic [31:0] ex_out, ex_store_data, mem_addr, mem_wdata, mem_rdata, wb_data;
  logic [2:0]  lsu_control;
  logic [4:0]  ex_rd, wb_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, wb_valid, wb_ready, wb_reg_write, wb_misalign;
  logic [3:0]  mem_be;
  int n_cmp = 0, n_err = 0;

  core_memory_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_out(ex_out),
    .ex_store_data(ex_store_data), .mem_op(mem_op), .lsu_control(lsu_control), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_misalign(wb_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; ex_valid = 0; ex_out = 0; ex_store_data = 0; mem_op = 0; lsu_control = 0;
    ex_rd = 0; ex_reg_write = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; wb_ready = 1;
    #1;
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    n_cmp++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL reset_ex_ready got %b exp 1", ex_ready); end
    n_cmp++; if (wb_data !== 32'h0 || mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_data got %h/%h exp 0/0", wb_data, mem_addr); end
    step(); step();
    rst_n = 1;
    step();
  endtask

  task automatic test_alu();
    ex_valid = 1; mem_op = 0; ex_out = 32'h0000_1234; ex_rd = 5; ex_reg_write = 1; wb_ready = 1;
    n_cmp++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL alu_ex_ready got %b exp 1", ex_ready); end
    step();
    ex_valid = 0;
    n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL alu_wb_valid got %b exp 1", wb_valid); end
    n_cmp++; if (wb_data !== 32'h1234 || wb_rd !== 5'd5 || wb_reg_write !== 1'b1) begin n_err++; $display("FAIL alu_result got %h rd %0d we %b exp 1234 rd 5 we 1", wb_data, wb_rd, wb_reg_write); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL alu_no_req got %b exp 0", mem_req); end
    step();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL alu_idle got %b exp 0", wb_valid); end
  endtask

  task automatic test_load_byte();
    ex_valid = 1; mem_op = 1; lsu_control = LSU_LB; ex_out = 32'h103; ex_rd = 7; ex_reg_write = 1;
    step();
    ex_valid = 0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b1111 || mem_we !== 1'b0) begin n_err++; $display("FAIL lb_req[%0d] got req %b addr %h be %b we %b exp 1 100 1111 0", i, mem_req, mem_addr, mem_be, mem_we); end
      step();
    end
    mem_gnt = 1;
    step();
    mem_gnt = 0;
    n_cmp++; if (mem_req !== 1'b0 || wb_valid !== 1'b0) begin n_err++; $display("FAIL lb_resp_wait got req %b valid %b exp 0 0", mem_req, wb_valid); end
    mem_rvalid = 1; mem_rdata = 32'h80FF_0000;
    step();
    mem_rvalid = 0;
    n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'hFFFF_FF80 || wb_reg_write !== 1'b1 || wb_rd !== 5'd7) begin n_err++; $display("FAIL lb_result got v %b %h we %b rd %0d exp 1 ffffff80 1 7", wb_valid, wb_data, wb_reg_write, wb_rd); end
    step();
  endtask

  task automatic test_store_half();
    ex_valid = 1; mem_op = 1; lsu_control = LSU_SH; ex_out = 32'h202; ex_store_data = 32'h1234_ABCD; ex_reg_write = 1;
    step();
    ex_valid = 0;
    n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1100 || mem_addr !== 32'h200) begin n_err++; $display("FAIL sh_req got req %b we %b be %b addr %h exp 1 1 1100 200", mem_req, mem_we, mem_be, mem_addr); end
    n_cmp++; if (mem_wdata !== 32'hABCD_ABCD) begin n_err++; $display("FAIL sh_wdata got %h exp abcdabcd", mem_wdata); end
    mem_gnt = 1; mem_rvalid = 1;
    step();
    mem_gnt = 0; mem_rvalid = 0;
    n_cmp++; if (wb_valid !== 1'b0 || mem_req !== 1'b0) begin n_err++; $display("FAIL sh_gnt_rvalid_same got valid %b req %b exp 0 0", wb_valid, mem_req); end
    mem_rvalid = 1;
    step();
    mem_rvalid = 0;
    n_cmp++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || wb_misalign !== 1'b0) begin n_err++; $display("FAIL sh_done got v %b we %b mis %b exp 1 0 0", wb_valid, wb_reg_write, wb_misalign); end
    step();
  endtask

  task automatic test_misalign();
    ex_valid = 1; mem_op = 1; lsu_control = LSU_LW; ex_out = 32'h301; ex_reg_write = 1;
    step();
    ex_valid = 0;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL mis_no_req got %b exp 0", mem_req); end
    n_cmp++; if (wb_valid !== 1'b1 || wb_misalign !== 1'b1 || wb_reg_write !== 1'b0) begin n_err++; $display("FAIL mis_flags got v %b mis %b we %b exp 1 1 0", wb_valid, wb_misalign, wb_reg_write); end
    step();
  endtask

  task automatic test_back_to_back();
    wb_ready = 0; ex_valid = 1; mem_op = 0; ex_out = 32'hAAAA; ex_rd = 1; ex_reg_write = 1;
    step();
    ex_out = 32'hBBBB; ex_rd = 2;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'hAAAA || wb_rd !== 5'd1 || ex_ready !== 1'b0) begin n_err++; $display("FAIL b2b_hold[%0d] got v %b %h rd %0d rdy %b exp 1 aaaa 1 0", i, wb_valid, wb_data, wb_rd, ex_ready); end
      step();
    end
    wb_ready = 1;
    #1;
    n_cmp++; if (ex_ready !== 1'b1 || wb_data !== 32'hAAAA) begin n_err++; $display("FAIL b2b_release got rdy %b %h exp 1 aaaa", ex_ready, wb_data); end
    step();
    ex_valid = 0;
    n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'hBBBB || wb_rd !== 5'd2) begin n_err++; $display("FAIL b2b_second got v %b %h rd %0d exp 1 bbbb 2", wb_valid, wb_data, wb_rd); end
    step();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL b2b_no_dup got %b exp 0", wb_valid); end
  endtask

  task automatic test_reset_during_req();
    ex_valid = 1; mem_op = 1; lsu_control = LSU_LW; ex_out = 32'h400;
    step();
    ex_valid = 0;
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rst_req_pre got %b exp 1", mem_req); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req_async got %b exp 0", mem_req); end
    step();
    rst_n = 1;
    step();
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 0;
    n_cmp++; if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin n_err++; $display("FAIL rst_stale_rvalid got v %b rdy %b exp 0 1", wb_valid, ex_ready); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_back_to_back();
    test_reset_during_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
